// File: rtl/delay_est.sv
// Integer-sample delay estimator between DPD reference and PA feedback, using
// sign-bit cross-correlation over lags 0..L-1. It is a one-shot measurement started by a pulse.
module delay_est #(
    parameter  int W  = 16,
    parameter  int L  = 32,
    parameter  int N  = 256,
    localparam int LW = $clog2(L),
    localparam int AW = $clog2(N) + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [W-1:0]  ref_in,
    input  logic signed [W-1:0]  fb_in,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [LW-1:0]        lag,
    output logic signed [AW-1:0] peak
);

    localparam int CW = $clog2((L > N) ? L : N);

    typedef enum logic [1:0] {IDLE, FILL, ACC, SEARCH} state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [L-1:1]          tap_q;
    logic [L-1:0]          ref_sgn;
    logic                  fb_sgn;
    logic signed [AW-1:0]  acc_q [L];
    logic signed [AW-1:0]  acc_sel;
    logic signed [AW-1:0]  best_q;
    logic [LW-1:0]         best_lag_q;
    logic                  unused_bits;

    // The sign bit is 1 for negative samples, so equal bits mean equal signs (zero counts as +1).
    assign ref_sgn     = {tap_q, ref_in[W-1]};
    assign fb_sgn      = fb_in[W-1];
    assign acc_sel     = acc_q[cnt_q[LW-1:0]];
    assign unused_bits = ^{ref_in[W-2:0], fb_in[W-2:0]};

    function automatic logic signed [AW-1:0] corr_step(input logic signed [AW-1:0] a,
                                                       input logic match);
        return match ? a + AW'(1) : a - AW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_q <= '0;
        end else begin
            tap_q <= ref_sgn[L-2:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            lag        <= '0;
            peak       <= '0;
            best_q     <= '0;
            best_lag_q <= '0;
            for (int k = 0; k < L; k++) acc_q[k] <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FILL;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        for (int k = 0; k < L; k++) acc_q[k] <= '0;
                    end
                end
                FILL: begin
                    if (cnt_q == CW'(L - 2)) begin
                        state_q <= ACC;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ACC: begin
                    for (int k = 0; k < L; k++) acc_q[k] <= corr_step(acc_q[k], fb_sgn == ref_sgn[k]);
                    if (cnt_q == CW'(N - 1)) begin
                        state_q    <= SEARCH;
                        cnt_q      <= '0;
                        best_q     <= '0;
                        best_lag_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SEARCH: begin
                    // acc[0] seeds the running best unconditionally; later lags need a strict win.
                    if (cnt_q == '0 || acc_sel > best_q) begin
                        best_q     <= acc_sel;
                        best_lag_q <= cnt_q[LW-1:0];
                    end
                    if (cnt_q == CW'(L - 1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        if (acc_sel > best_q) begin
                            lag  <= cnt_q[LW-1:0];
                            peak <= acc_sel;
                        end else begin
                            lag  <= best_lag_q;
                            peak <= best_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_est.sv
// Scoreboard bench for delay_est: runs push expected lag/peak/done-edge, and a monitor
// pops and compares on every done pulse.
module tb_delay_est;

    localparam int W   = 16;
    localparam int L   = 32;
    localparam int N   = 256;
    localparam int LW  = $clog2(L);
    localparam int AW  = $clog2(N) + 2;
    localparam int SZ  = 32768;
    localparam int LAT = 2 * L + N - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic signed [W-1:0]  ref_in;
    logic signed [W-1:0]  fb_in;
    logic                 busy;
    logic                 done;
    logic [LW-1:0]        lag;
    logic signed [AW-1:0] peak;

    delay_est #(.W(W), .L(L), .N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .ref_in (ref_in),
        .fb_in  (fb_in),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .lag    (lag),
        .peak   (peak)
    );

    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    logic signed [W-1:0] refh [SZ];
    logic signed [W-1:0] fbh  [SZ];

    typedef struct {
        int lag;
        int peak;
        int edge_n;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sample index j is presented to the DUT ahead of rising edge number j.
    always @(negedge clk) begin
        ref_in = refh[ecnt];
        fb_in  = fbh[ecnt];
    end

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", ecnt - 1, -1);
            end else begin
                got = sb.pop_front();
                chk("lag", int'(lag), got.lag);
                chk("peak", int'(peak), got.peak);
                chk("done_edge", ecnt - 1, got.edge_n);
                chk("busy_at_done", int'(busy), 0);
            end
        end
    end

    task automatic gen(input int s, input int d, input int mode, input bit noise);
        logic [31:0] r;
        for (int j = s + 1; j <= s + LAT + 1; j++) begin
            r = $urandom();
            if (mode == 1)      refh[j] = 16'sd100;
            else if (mode == 2) refh[j] = 16'sd0;
            else                refh[j] = r[W-1:0];
        end
        for (int j = s + 1; j <= s + LAT + 1; j++) begin
            if (mode == 1)      fbh[j] = 16'sd3;
            else if (mode == 2) fbh[j] = -16'sd1;
            else                fbh[j] = refh[j - d];
            if (noise && $urandom_range(9, 0) == 0) fbh[j][W-1] = ~fbh[j][W-1];
        end
    endtask

    task automatic model(input int s, output int ml, output int mp);
        int a;
        ml = 0;
        mp = 0;
        for (int k = 0; k < L; k++) begin
            a = 0;
            for (int j = s + L; j < s + L + N; j++)
                a += (fbh[j][W-1] == refh[j - k][W-1]) ? 1 : -1;
            if (k == 0 || a > mp) begin
                mp = a;
                ml = k;
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge inside the done cycle.
    task automatic do_run(input int d, input int mode, input bit noise, input bit extra,
                          input bit use_model, input int exp_lag, input int exp_peak);
        int s;
        int ml;
        int mp;
        exp_t e;
        s = ecnt;
        gen(s, d, mode, noise);
        e.lag    = exp_lag;
        e.peak   = exp_peak;
        e.edge_n = s + LAT;
        if (use_model) begin
            model(s, ml, mp);
            e.lag  = d;
            e.peak = mp;
        end
        sb.push_back(e);
        start = 1'b1;
        for (int i = 1; i <= LAT + 1; i++) begin
            @(negedge clk);
            start = extra && (i == 10 || i == 300);
            if (i == 1 || i == LAT) chk("busy_during_run", int'(busy), 1);
        end
        start = 1'b0;
    endtask

    initial begin
        int s;
        rst   = 1'b1;
        start = 1'b0;
        for (int j = 0; j < SZ; j++) begin
            refh[j] = '0;
            fbh[j]  = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_lag", int'(lag), 0);
        chk("rst_peak", int'(peak), 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);

        // Runs are back to back: each start lands in the previous run's done cycle.
        do_run(5, 0, 1'b0, 1'b1, 1'b0, 5, 256);
        do_run(31, 0, 1'b0, 1'b0, 1'b0, 31, 256);
        do_run(0, 0, 1'b0, 1'b0, 1'b0, 0, 256);
        do_run(0, 1, 1'b0, 1'b0, 1'b0, 0, 256);
        do_run(0, 2, 1'b0, 1'b0, 1'b0, 0, -256);
        for (int r = 0; r < 50; r++)
            do_run($urandom_range(31, 0), 0, 1'b1, 1'b0, 1'b1, 0, 0);
        do_run(9, 0, 1'b0, 1'b0, 1'b0, 9, 256);

        // Abort a run during accumulation.
        s = ecnt;
        gen(s, 3, 0, 1'b0);
        start = 1'b1;
        repeat (100) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("busy_before_abort", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_lag", int'(lag), 0);
        chk("abort_peak", int'(peak), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (400) @(negedge clk);
        do_run(12, 0, 1'b0, 1'b0, 1'b0, 12, 256);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_est.md
# delay_est

Estimates the integer-sample delay between the DPD transmit reference and the PA feedback signal. It does this by sign-bit cross-correlation over a window of lags. The block sits at the observation side of the DPD loop. Its `lag` result programs the alignment delay on the reference path, so the two paths line up before the coefficient estimator. Measurement is one-shot, started by a pulse; samples arrive every clock with no valid strobe.

## Interface
- `W`, 16, sample width of `ref_in` and `fb_in` (two's complement)
- `L`, 32, number of lags searched, 0..L-1; L ≥ 2
- `N`, 256, correlation length in samples; power of two, N ≥ 4
- `clk`  in  1  clock; all registers on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ref_in`  in  W  transmit reference sample, signed
- `fb_in`  in  W  feedback sample, signed
- `start`  in  1  one-cycle request; honoured only in IDLE
- `busy`  out  1  high from the cycle after an accepted start until done
- `done`  out  1  one-cycle pulse; `lag`/`peak` valid from this cycle
- `lag`  out  $clog2(L)  lag of the correlation maximum (fb lags ref by `lag` samples)
- `peak`  out  AW = $clog2(N)+2  signed correlation value at `lag`

## Operation
- **Sign mapping:** s(x) = −1 if x[W-1]=1, else +1. Zero maps to +1.
- **Reference sign shift register:** taps 1..L-1. Tap 0 is the sign of the current `ref_in` (combinational).
  - The register shifts on every clock in every state.
  - Tap k holds s(ref_in) from k edges earlier.
- **Accumulators:** L signed accumulators acc[k], each AW bits.
  - In ACC, on each edge, acc[k] += +1 if s(fb_in) equals tap k, else −1.
  - Range is −N..+N; no overflow is possible at AW.
- **FSM states:** IDLE, FILL, ACC, SEARCH.
  - IDLE: on `start`=1, go to FILL. Clear the cycle counter and all acc[k]. `busy`←1.
  - FILL: L-1 edges, so that every tap holds samples taken at or after the start edge. Then go to ACC.
  - ACC: N edges of accumulation. Then go to SEARCH with index i=0, best = acc[0], best_lag = 0.
  - SEARCH: L edges, examining acc[i] for i = 0..L-1.
    - best is updated only when acc[i] > best (strict greater), so on ties the lowest lag wins.
    - On the last SEARCH edge: `lag`←best_lag, `peak`←best, `done`←1, `busy`←0, go to IDLE.
- Maximum is signed. An inverted feedback path (peak near −N) is not detected as a match; this is by design, since the PA path is non-inverting.
- `start` outside IDLE is ignored; it is neither queued nor does it restart the measurement.
- `lag` and `peak` hold their values until the next `done`.
- **Counters:** a single counter sized for max(L, N) serves FILL, ACC and SEARCH.

## Timing
- **Reset values:** state IDLE, `busy`=0, `done`=0, `lag`=0, `peak`=0. All acc[k], taps, counters and best registers are 0.
- **Reset mid-measurement:** the block aborts immediately. No `done` pulse is produced and outputs return to their reset values. The next `start` after `rst` deasserts runs a full measurement.
- **Edge numbering:** the start edge is E0.
  - FILL: E1..E(L-1).
  - ACC: E(L)..E(L+N-1). ACC uses `fb_in` and taps as sampled at each of these edges.
  - SEARCH: E(L+N)..E(2L+N-1).
  - `done` is registered at E(2L+N-1). With the defaults this is E319, i.e. `done` is high in the cycle 319 clocks after the start cycle.
- `busy`=1 from E0 to E(2L+N-1), exclusive of the done cycle.
- `done` is high for exactly one cycle. The state is already IDLE in that cycle, so a `start` in the `done` cycle is accepted.
- **Lag reference:** relative to ACC, fb sample at edge Ej is correlated with the ref sample at edge E(j−k). An external `delay_rg` with D=d on ref-to-fb gives `lag`=d.

## Test plan
- **Known delay:** ref = random ±values (sign random), fb = ref through a d=5 delay line, start once. Required: `done` 319 cycles after start, `lag`=5, `peak`=256, `busy` high throughout and low at `done`.
- **Boundary lag:** same as above with d=31. Required: `lag`=31, `peak`=256. Then repeat with d=0: `lag`=0, `peak`=256.
- **Tie / constant input:** ref=+100, fb=+3 (all signs +1, so every acc=256). Required: `lag`=0, `peak`=256. Also ref=0, fb=−1 (every acc=−256). Required: `lag`=0, `peak`=−256.
- **Start handling:** extra `start` pulses at +10 and +300 cycles after the first start have no effect; result and `done` timing are unchanged. A `start` in the `done` cycle launches a second run, with its `done` 319 cycles later.
- **Reset mid-run:** assert `rst` during ACC. Required: `busy`/`done`/`lag`/`peak` go to 0 immediately and no `done` pulse appears. A fresh start with d=12 then yields `lag`=12, `peak`=256.
- **Random sweep:** 50 runs with random d in 0..31, random data and random noise flipping 10% of fb signs. Required: `lag`=d every run, and `peak` equals the model value computed from the same data.
